axis_frame_gen: RTL and testbench

- AXI-Stream frame transmitter that drives test and bring-up traffic into stream consumers such as width adapters, FIFOs and MACs.
- On a start pulse it emits a programmed number of frames. Each frame has a programmed byte length and a deterministic byte pattern, with correct tkeep on the last beat and a programmable idle gap between frames.
- Sits at the source end of an AXI-Stream link and fully honours tready backpressure.

---
 rtl/axis_frame_gen.sv | 161 ++++++++++++++++
 tb/tb_axis_frame_gen.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_gen.sv
//==============================================================================
// axis_frame_gen : AXI-Stream test-frame source with length/pattern/gap control.
// Optional tuser error injection: define AXIS_FRAME_GEN_ERR_INJECT_EN.
// Revision: 1.0
//==============================================================================
`default_nettype none

module axis_frame_gen #(
   parameter int DATA_WIDTH = 64,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8,
   parameter int LEN_WIDTH  = 16,
   parameter int GAP_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [LEN_WIDTH-1:0]  frame_len,
   input  logic [15:0]           frame_count,
   input  logic [GAP_WIDTH-1:0]  gap,
   input  logic [7:0]            seed,
`ifdef AXIS_FRAME_GEN_ERR_INJECT_EN
   input  logic [7:0]            err_every,
`endif
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] output_axis_tdata,
   output logic [KEEP_WIDTH-1:0] output_axis_tkeep,
   output logic                  output_axis_tvalid,
   input  logic                  output_axis_tready,
   output logic                  output_axis_tlast,
   output logic                  output_axis_tuser
);

   localparam int CW = LEN_WIDTH + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SEND = 2'd1;
   localparam logic [1:0] S_GAP  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]           r_state;
   logic [CW-1:0]        r_len;
   logic [CW-1:0]        r_byte_cnt;
   logic [15:0]          r_frames_left;
   logic [7:0]           r_fidx;
   logic [GAP_WIDTH-1:0] r_gap;
   logic [GAP_WIDTH-1:0] r_gap_cnt;
   logic [7:0]           r_seed;

   logic [CW-1:0]         w_remain;
   logic                  w_last;
   logic                  w_valid;
   logic                  w_xfer;
   logic [7:0]            w_base;
   logic [KEEP_WIDTH-1:0] w_keep;
   logic [DATA_WIDTH-1:0] w_data;
   logic                  w_err_hit;

   // Outputs decode purely from registers, so they hold while the sink stalls.
   assign w_remain = r_len - r_byte_cnt;
   assign w_last   = (w_remain <= CW'(KEEP_WIDTH));
   assign w_valid  = (r_state == S_SEND);
   assign w_xfer   = w_valid & output_axis_tready;
   assign w_base   = r_seed + r_fidx + r_byte_cnt[7:0];

   genvar k;
   generate
      for (k = 0; k < KEEP_WIDTH; k++) begin : g_lane
         assign w_keep[k]       = w_valid & (~w_last | (w_remain > CW'(k)));
         assign w_data[8*k +: 8] = w_keep[k] ? (w_base + 8'(k)) : 8'h00;
      end
   endgenerate

`ifdef AXIS_FRAME_GEN_ERR_INJECT_EN
   logic [7:0] r_err_every;
   logic [7:0] r_err_cnt;

   assign w_err_hit = (r_err_every != 8'd0) && (r_err_cnt == r_err_every - 8'd1);

   // r_err_cnt tracks frame index modulo err_every.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err_every <= 8'd0;
         r_err_cnt   <= 8'd0;
      end else if (r_state == S_IDLE) begin
         if (start && frame_count != 16'd0) begin
            r_err_every <= err_every;
            r_err_cnt   <= 8'd0;
         end
      end else if (w_xfer && w_last) begin
         r_err_cnt <= w_err_hit ? 8'd0 : r_err_cnt + 8'd1;
      end
   end
`else
   assign w_err_hit = 1'b0;
`endif

   assign busy               = (r_state != S_IDLE);
   assign done               = (r_state == S_DONE);
   assign output_axis_tvalid = w_valid;
   assign output_axis_tdata  = w_data;
   assign output_axis_tkeep  = w_keep;
   assign output_axis_tlast  = w_valid & w_last;
   assign output_axis_tuser  = w_valid & w_last & w_err_hit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_len         <= '0;
         r_byte_cnt    <= '0;
         r_frames_left <= 16'd0;
         r_fidx        <= 8'd0;
         r_gap         <= '0;
         r_gap_cnt     <= '0;
         r_seed        <= 8'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start && frame_count != 16'd0) begin
                  r_len         <= (frame_len == '0) ? CW'(1) : CW'(frame_len);
                  r_frames_left <= frame_count;
                  r_gap         <= gap;
                  r_seed        <= seed;
                  r_byte_cnt    <= '0;
                  r_fidx        <= 8'd0;
                  r_state       <= S_SEND;
               end
            end
            S_SEND: begin
               if (w_xfer) begin
                  if (!w_last) begin
                     r_byte_cnt <= r_byte_cnt + CW'(KEEP_WIDTH);
                  end else begin
                     r_byte_cnt    <= '0;
                     r_frames_left <= r_frames_left - 16'd1;
                     r_fidx        <= r_fidx + 8'd1;
                     if (r_frames_left == 16'd1) begin
                        r_state <= S_DONE;
                     end else if (r_gap != '0) begin
                        r_gap_cnt <= r_gap;
                        r_state   <= S_GAP;
                     end
                  end
               end
            end
            S_GAP: begin
               if (r_gap_cnt == GAP_WIDTH'(1)) begin
                  r_state <= S_SEND;
               end else begin
                  r_gap_cnt <= r_gap_cnt - GAP_WIDTH'(1);
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_axis_frame_gen.sv
//==============================================================================
// tb_axis_frame_gen : directed vector bench for axis_frame_gen (DATA_WIDTH=64).
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_axis_frame_gen;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] frame_len = '0;
   logic [15:0] frame_count = '0;
   logic [7:0]  gap = '0;
   logic [7:0]  seed = '0;
   logic [7:0]  err_every = '0;
   logic        busy, done;
   logic [63:0] tdata;
   logic [7:0]  tkeep;
   logic        tvalid, tlast, tuser;
   logic        tready = 1'b1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   axis_frame_gen #(
      .DATA_WIDTH(64), .KEEP_WIDTH(8), .LEN_WIDTH(16), .GAP_WIDTH(8)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .frame_len(frame_len), .frame_count(frame_count), .gap(gap), .seed(seed),
`ifdef AXIS_FRAME_GEN_ERR_INJECT_EN
      .err_every(err_every),
`endif
      .busy(busy), .done(done),
      .output_axis_tdata(tdata), .output_axis_tkeep(tkeep),
      .output_axis_tvalid(tvalid), .output_axis_tready(tready),
      .output_axis_tlast(tlast), .output_axis_tuser(tuser)
   );

   typedef struct {
      int len; int cnt; int gap; int seed; int err; int poke;
      int exp_beats; int exp_keep; int exp_fb; int exp_done; int exp_idle;
   } vec_t;

   vec_t tv[8];

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] pat(input logic [7:0] base, input int rem);
      logic [63:0] r = '0;
      for (int k = 0; k < 8; k++)
         if (k < rem) r[8*k +: 8] = base + 8'(k);
      return r;
   endfunction

   function automatic logic [7:0] keep_of(input int rem);
      return (rem >= 8) ? 8'hFF : 8'((1 << rem) - 1);
   endfunction

   task automatic run_vec(input vec_t v);
      int L = (v.len == 0) ? 1 : v.len;
      int f = 0, i = 0, beats = 0, idle = 0, n = 0, rem;
      logic [7:0] fb = '0, lastkeep = '0;
      logic exp_last, exp_user;
      bit got = 0;
      @(negedge clk);
      frame_len = 16'(v.len); frame_count = 16'(v.cnt); gap = 8'(v.gap);
      seed = 8'(v.seed); err_every = 8'(v.err); start = 1'b1;
      @(negedge clk);
      start = 1'b0; frame_len = 16'd3; frame_count = 16'd7; gap = 8'd9;
      seed = 8'h55; err_every = 8'd1;
      while (n < 300 && !got) begin
         n++;
         start = (v.poke != 0 && n == 2);
         if (tvalid) begin
            rem = L - i;
            exp_last = (rem <= 8);
`ifdef AXIS_FRAME_GEN_ERR_INJECT_EN
            exp_user = exp_last && v.err != 0 && ((f + 1) % v.err) == 0;
`else
            exp_user = 1'b0;
`endif
            check("beat", {6'd0, tuser, tlast, tkeep, tdata},
                  {6'd0, exp_user, exp_last, keep_of(rem), pat(8'(v.seed + f + i), rem)});
            if (f == v.cnt - 1 && i == 0) fb = tdata[7:0];
            beats++;
            if (exp_last) begin
               lastkeep = tkeep; f++; i = 0;
            end else begin
               i += 8;
            end
         end else if (!done) begin
            idle++;
         end
         if (done) begin
            got = 1;
            check("busy_at_done", 80'(busy), 80'd1);
         end
         @(negedge clk);
      end
      start = 1'b0;
      check("done_seen", 80'(got), 80'd1);
      check("beat_count", 80'(beats), 80'(v.exp_beats));
      check("last_keep", 80'(lastkeep), 80'(v.exp_keep));
      check("last_frame_byte0", 80'(fb), 80'(v.exp_fb));
      check("done_cycle", 80'(n), 80'(v.exp_done));
      check("idle_cycles", 80'(idle), 80'(v.exp_idle));
      check("after_done", {77'd0, busy, done, tvalid}, 80'd0);
      if (v.poke != 0) begin
         for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("no_queued_start", {78'd0, busy, tvalid}, 80'd0);
         end
      end
   endtask

   initial begin
      int n, b;
      bit got;
      logic [74:0] snap;

      tv[0] = '{len:20, cnt:1, gap:0, seed:'h10, err:0, poke:0, exp_beats:3, exp_keep:'h0F, exp_fb:'h10, exp_done:4, exp_idle:0};
      tv[1] = '{len:16, cnt:2, gap:0, seed:'h10, err:0, poke:1, exp_beats:4, exp_keep:'hFF, exp_fb:'h11, exp_done:5, exp_idle:0};
      tv[2] = '{len:8,  cnt:2, gap:3, seed:'h00, err:0, poke:0, exp_beats:2, exp_keep:'hFF, exp_fb:'h01, exp_done:6, exp_idle:3};
      tv[3] = '{len:1,  cnt:1, gap:0, seed:'hAA, err:0, poke:0, exp_beats:1, exp_keep:'h01, exp_fb:'hAA, exp_done:2, exp_idle:0};
      tv[4] = '{len:0,  cnt:1, gap:5, seed:'h05, err:0, poke:0, exp_beats:1, exp_keep:'h01, exp_fb:'h05, exp_done:2, exp_idle:0};
      tv[5] = '{len:9,  cnt:3, gap:1, seed:'hFE, err:0, poke:0, exp_beats:6, exp_keep:'h01, exp_fb:'h00, exp_done:9, exp_idle:2};
      tv[6] = '{len:64, cnt:1, gap:0, seed:'hF0, err:0, poke:0, exp_beats:8, exp_keep:'hFF, exp_fb:'hF0, exp_done:9, exp_idle:0};
      tv[7] = '{len:8,  cnt:4, gap:0, seed:'h00, err:2, poke:0, exp_beats:4, exp_keep:'hFF, exp_fb:'h03, exp_done:5, exp_idle:0};

      repeat (2) @(negedge clk);
      check("reset_outputs", {5'd0, busy, done, tvalid, tlast, tuser, tkeep, tdata}, 80'd0);
      rst = 1'b0;

      for (int k = 0; k < 8; k++) run_vec(tv[k]);

      // Backpressure: 40-byte frame, sink stalls three cycles on beat 1.
      @(negedge clk);
      frame_len = 16'd40; frame_count = 16'd1; gap = 8'd0; seed = 8'h20; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0; b = 0; got = 0; snap = '0;
      while (n < 100 && !got) begin
         n++;
         tready = !(n >= 2 && n <= 4);
         if (n == 2) begin
            snap = {tvalid, tlast, tkeep, tdata};
            check("bp_valid_presented", 80'(tvalid), 80'd1);
         end
         if (n > 2 && !tready)
            check("bp_hold", 80'({tvalid, tlast, tkeep, tdata}), 80'(snap));
         if (tvalid && tready) begin
            check("bp_beat", {7'd0, tlast, tkeep, tdata},
                  {7'd0, (b == 4), 8'hFF, pat(8'(8'h20 + 8 * b), 8)});
            b++;
         end
         if (done) got = 1;
         @(negedge clk);
      end
      tready = 1'b1;
      check("bp_beats", 80'(b), 80'd5);
      check("bp_done_cycle", 80'(n), 80'd9);

      // frame_count = 0 must not start a run.
      @(negedge clk);
      frame_len = 16'd8; frame_count = 16'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 4; c++) begin
         check("fc0_idle", {78'd0, busy, tvalid}, 80'd0);
         @(negedge clk);
      end

      // Asynchronous reset in the middle of a frame.
      frame_len = 16'd40; frame_count = 16'd1; seed = 8'h30; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("pre_reset_valid", 80'(tvalid), 80'd1);
      #2 rst = 1'b1;
      #1 check("async_reset", {5'd0, busy, done, tvalid, tlast, tuser, tkeep, tdata}, 80'd0);
      @(negedge clk);
      rst = 1'b0;
      run_vec(tv[3]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
